// File: rtl/aes128_decrypt_iter_if.sv
// rtl/aes128_decrypt_iter_if.sv - start/busy/done block interface of the AES-128 decryptor
interface aes128_decrypt_iter_if;
   logic         start;
   logic [127:0] key;
   logic [127:0] in;
   logic         busy;
   logic         done;
   logic [127:0] out;

   modport master (output start, output key, output in, input busy, input done, input out);
   modport slave  (input start, input key, input in, output busy, output done, output out);
endinterface

// File: rtl/aes128_decrypt_iter.sv
// rtl/aes128_decrypt_iter.sv - iterative AES-128 inverse cipher, one round per clock
package aes128_decrypt_iter_pkg;
   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] x;
      p = 8'h00;
      x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = xtime(x);
      end
      return p;
   endfunction

   // a^254 is the multiplicative inverse in GF(2^8) and maps 0 to 0
   function automatic logic [7:0] ginv(input logic [7:0] a);
      logic [7:0] r;
      logic [7:0] s;
      r = 8'h01;
      s = a;
      for (int i = 0; i < 7; i++) begin
         s = gmul(s, s);
         r = gmul(r, s);
      end
      return r;
   endfunction

   function automatic logic [7:0] sbox(input logic [7:0] a);
      logic [7:0] b;
      b = ginv(a);
      return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
   endfunction

   function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
      logic [127:0] o;
      logic [7:0]   a0, a1, a2, a3;
      o = '0;
      for (int c = 0; c < 4; c++) begin
         a0 = s[127-32*c -: 8];
         a1 = s[119-32*c -: 8];
         a2 = s[111-32*c -: 8];
         a3 = s[103-32*c -: 8];
         o[127-32*c -: 32] = {
            gmul(8'h0e, a0) ^ gmul(8'h0b, a1) ^ gmul(8'h0d, a2) ^ gmul(8'h09, a3),
            gmul(8'h09, a0) ^ gmul(8'h0e, a1) ^ gmul(8'h0b, a2) ^ gmul(8'h0d, a3),
            gmul(8'h0d, a0) ^ gmul(8'h09, a1) ^ gmul(8'h0e, a2) ^ gmul(8'h0b, a3),
            gmul(8'h0b, a0) ^ gmul(8'h0d, a1) ^ gmul(8'h09, a2) ^ gmul(8'h0e, a3)};
      end
      return o;
   endfunction

   // Round keys rk0..rk10 packed with rk0 in the MSBs
   function automatic logic [1407:0] key_expand(input logic [127:0] k);
      logic [31:0]   w [0:43];
      logic [31:0]   t;
      logic [7:0]    rc;
      logic [1407:0] res;
      for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
      rc = 8'h01;
      for (int i = 4; i < 44; i++) begin
         t = w[i-1];
         if (i % 4 == 0) begin
            t  = {sbox(t[23:16]), sbox(t[15:8]), sbox(t[7:0]), sbox(t[31:24])} ^ {rc, 24'h000000};
            rc = xtime(rc);
         end
         w[i] = w[i-4] ^ t;
      end
      res = '0;
      for (int i = 0; i < 44; i++) res[1407-32*i -: 32] = w[i];
      return res;
   endfunction
endpackage

module aes_inv_sbox (
   input  logic [7:0] a,
   output logic [7:0] y
);
   import aes128_decrypt_iter_pkg::*;

   logic [7:0] b;

   always_comb begin
      b = {a[6:0], a[7]} ^ {a[4:0], a[7:5]} ^ {a[1:0], a[7:2]} ^ 8'h05;
      y = ginv(b);
   end
endmodule

module aes128_decrypt_iter #(
   parameter int NR = 10
) (
   input  logic                 clk,
   input  logic                 rst,
   aes128_decrypt_iter_if.slave bus
);
   import aes128_decrypt_iter_pkg::*;

   typedef enum logic [1:0] {IDLE, ROUND, FINAL} fsm_e;

   fsm_e         fsm_q, fsm_d;
   logic [127:0] blk_q, blk_d;
   logic [127:0] key_q, key_d;
   logic [127:0] out_q, out_d;
   logic [3:0]   rnd_q, rnd_d;
   logic         busy_q, busy_d;
   logic         done_q, done_d;

   logic [127:0]  key_sel;
   logic [1407:0] rk_all;
   logic [127:0]  rk [0:10];
   logic [127:0]  isr;
   wire  [127:0]  isb;

   // In IDLE the expander sees the live key so rk10 is ready on the accepting edge
   assign key_sel = (fsm_q == IDLE) ? bus.key : key_q;

   always_comb begin
      rk_all = key_expand(key_sel);
      for (int i = 0; i < 11; i++) rk[i] = rk_all[1407-128*i -: 128];
   end

   always_comb begin
      isr = '0;
      for (int c = 0; c < 4; c++)
         for (int r = 0; r < 4; r++)
            isr[127-8*(4*c+r) -: 8] = blk_q[127-8*(4*((c-r+4)%4)+r) -: 8];
   end

   for (genvar n = 0; n < 16; n++) begin : g_isb
      aes_inv_sbox u_isb (.a(isr[127-8*n -: 8]), .y(isb[127-8*n -: 8]));
   end

   always_comb begin
      fsm_d  = fsm_q;
      blk_d  = blk_q;
      key_d  = key_q;
      out_d  = out_q;
      rnd_d  = rnd_q;
      busy_d = busy_q;
      done_d = 1'b0;
      case (fsm_q)
         IDLE: begin
            if (bus.start) begin
               blk_d  = bus.in ^ rk[10];
               key_d  = bus.key;
               rnd_d  = 4'(NR - 1);
               busy_d = 1'b1;
               fsm_d  = ROUND;
            end
         end
         ROUND: begin
            blk_d = inv_mix_columns(isb ^ rk[rnd_q]);
            if (rnd_q == 4'd1) fsm_d = FINAL;
            else               rnd_d = rnd_q - 4'd1;
         end
         FINAL: begin
            out_d  = isb ^ rk[0];
            done_d = 1'b1;
            busy_d = 1'b0;
            fsm_d  = IDLE;
         end
         default: fsm_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         fsm_q  <= IDLE;
         blk_q  <= '0;
         key_q  <= '0;
         out_q  <= '0;
         rnd_q  <= '0;
         busy_q <= 1'b0;
         done_q <= 1'b0;
      end else begin
         fsm_q  <= fsm_d;
         blk_q  <= blk_d;
         key_q  <= key_d;
         out_q  <= out_d;
         rnd_q  <= rnd_d;
         busy_q <= busy_d;
         done_q <= done_d;
      end
   end

   assign bus.busy = busy_q;
   assign bus.done = done_q;
   assign bus.out  = out_q;
endmodule

// File: tb/tb_aes128_decrypt_iter.sv
// tb/tb_aes128_decrypt_iter.sv - directed and round-trip bench for aes128_decrypt_iter
module tb_aes128_decrypt_iter;
   localparam logic [127:0] K_C1 = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] C_C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
   localparam logic [127:0] P_C1 = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] K_B  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] C_B  = 128'h3925841d02dc09fbdc118597196a0b32;
   localparam logic [127:0] P_B  = 128'h3243f6a8885a308d313198a2e0370734;

   logic clk = 1'b0;
   logic rst;
   int   checks = 0;
   int   errors = 0;
   logic [7:0] sb_tab [0:255];

   aes128_decrypt_iter_if bus ();
   aes128_decrypt_iter dut (.clk(clk), .rst(rst), .bus(bus));

   always #5 clk = ~clk;

   function automatic logic [7:0] m_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] x;
      p = 8'h00;
      x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      end
      return p;
   endfunction

   // Forward S-box by brute-force inverse search plus bitwise affine map
   task automatic build_sbox;
      logic [7:0] inv;
      logic [7:0] s;
      logic [7:0] cst;
      cst = 8'h63;
      for (int x = 0; x < 256; x++) begin
         inv = 8'h00;
         for (int y = 1; y < 256; y++)
            if (m_mul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
         for (int i = 0; i < 8; i++)
            s[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8] ^ cst[i];
         sb_tab[x] = s;
      end
   endtask

   function automatic logic [127:0] m_encrypt(input logic [127:0] k, input logic [127:0] p);
      logic [31:0]  w [0:43];
      logic [31:0]  t;
      logic [7:0]   rc;
      logic [7:0]   s [0:15];
      logic [7:0]   u [0:15];
      logic [7:0]   a0, a1, a2, a3;
      logic [127:0] res;
      for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
      rc = 8'h01;
      for (int i = 4; i < 44; i++) begin
         t = w[i-1];
         if (i % 4 == 0) begin
            t  = {sb_tab[t[23:16]], sb_tab[t[15:8]], sb_tab[t[7:0]], sb_tab[t[31:24]]} ^ {rc, 24'h0};
            rc = m_mul(rc, 8'h02);
         end
         w[i] = w[i-4] ^ t;
      end
      for (int n = 0; n < 16; n++) s[n] = p[127-8*n -: 8] ^ w[n/4][31-8*(n%4) -: 8];
      for (int rnd = 1; rnd <= 10; rnd++) begin
         for (int n = 0; n < 16; n++) u[n] = sb_tab[s[n]];
         for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++) s[4*c+r] = u[4*((c+r)%4)+r];
         if (rnd != 10) begin
            for (int c = 0; c < 4; c++) begin
               a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
               s[4*c]   = m_mul(a0, 8'h02) ^ m_mul(a1, 8'h03) ^ a2 ^ a3;
               s[4*c+1] = a0 ^ m_mul(a1, 8'h02) ^ m_mul(a2, 8'h03) ^ a3;
               s[4*c+2] = a0 ^ a1 ^ m_mul(a2, 8'h02) ^ m_mul(a3, 8'h03);
               s[4*c+3] = m_mul(a0, 8'h03) ^ a1 ^ a2 ^ m_mul(a3, 8'h02);
            end
         end
         for (int n = 0; n < 16; n++) s[n] = s[n] ^ w[4*rnd + n/4][31-8*(n%4) -: 8];
      end
      res = '0;
      for (int n = 0; n < 16; n++) res[127-8*n -: 8] = s[n];
      return res;
   endfunction

   task automatic test_reset;
      rst = 1'b1;
      bus.start = 1'b0;
      bus.key = '0;
      bus.in = '0;
      repeat (2) @(negedge clk);
      checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b need 0", bus.busy); end
      checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b need 0", bus.done); end
      checks++; if (bus.out !== 128'h0) begin errors++; $display("FAIL reset_out: got %h need 0", bus.out); end
      rst = 1'b0;
   endtask

   task automatic test_c1;
      @(negedge clk);
      bus.start = 1'b1; bus.key = K_C1; bus.in = C_C1;
      for (int e = 1; e <= 11; e++) begin
         @(negedge clk);
         bus.start = 1'b0;
         checks++; if (bus.done !== (e == 11)) begin errors++; $display("FAIL c1_done[%0d]: got %b need %b", e, bus.done, e == 11); end
         checks++; if (bus.busy !== (e <= 10)) begin errors++; $display("FAIL c1_busy[%0d]: got %b need %b", e, bus.busy, e <= 10); end
      end
      checks++; if (bus.out !== P_C1) begin errors++; $display("FAIL c1_out: got %h need %h", bus.out, P_C1); end
   endtask

   task automatic test_appb_latch;
      @(negedge clk);
      bus.start = 1'b1; bus.key = K_B; bus.in = C_B;
      for (int e = 1; e <= 11; e++) begin
         @(negedge clk);
         bus.start = 1'b0;
         if (e == 1) begin
            bus.key = {$urandom, $urandom, $urandom, $urandom};
            bus.in  = {$urandom, $urandom, $urandom, $urandom};
         end
         checks++; if (bus.done !== (e == 11)) begin errors++; $display("FAIL appb_done[%0d]: got %b need %b", e, bus.done, e == 11); end
      end
      checks++; if (bus.out !== P_B) begin errors++; $display("FAIL appb_out: got %h need %h", bus.out, P_B); end
      repeat (3) @(negedge clk);
      checks++; if (bus.out !== P_B) begin errors++; $display("FAIL appb_hold: got %h need %h", bus.out, P_B); end
      checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL appb_done_low: got %b need 0", bus.done); end
   endtask

   task automatic test_back_to_back;
      int dones, first, second;
      dones = 0; first = 0; second = 0;
      @(negedge clk);
      bus.start = 1'b1; bus.key = K_C1; bus.in = C_C1;
      for (int e = 1; e <= 34; e++) begin
         @(negedge clk);
         if (e == 1) begin bus.key = K_B; bus.in = C_B; end
         if (e == 12) bus.start = 1'b0;
         if (e == 16) bus.start = 1'b1;
         if (e == 17) bus.start = 1'b0;
         if (bus.done === 1'b1) begin
            dones++;
            if (dones == 1) begin
               first = e;
               checks++; if (bus.out !== P_C1) begin errors++; $display("FAIL b2b_out1: got %h need %h", bus.out, P_C1); end
            end else if (dones == 2) begin
               second = e;
               checks++; if (bus.out !== P_B) begin errors++; $display("FAIL b2b_out2: got %h need %h", bus.out, P_B); end
            end
         end
         if (e == 12) begin
            checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL b2b_no_gap: busy %b need 1", bus.busy); end
         end
      end
      checks++; if (first != 11) begin errors++; $display("FAIL b2b_first: done at edge %0d need 11", first); end
      checks++; if (second != 22) begin errors++; $display("FAIL b2b_second: done at edge %0d need 22", second); end
      checks++; if (dones != 2) begin errors++; $display("FAIL b2b_count: %0d done pulses need 2", dones); end
   endtask

   task automatic test_reset_mid;
      int seen;
      @(negedge clk);
      bus.start = 1'b1; bus.key = K_C1; bus.in = C_C1;
      for (int e = 1; e <= 4; e++) begin
         @(negedge clk);
         bus.start = 1'b0;
      end
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy: got %b need 0", bus.busy); end
      checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL rstmid_done: got %b need 0", bus.done); end
      checks++; if (bus.out !== 128'h0) begin errors++; $display("FAIL rstmid_out: got %h need 0", bus.out); end
      seen = 0;
      for (int e = 0; e < 15; e++) begin
         @(negedge clk);
         if (bus.done === 1'b1) seen++;
      end
      checks++; if (seen != 0) begin errors++; $display("FAIL rstmid_no_done: %0d done pulses need 0", seen); end
      test_c1();
   endtask

   task automatic test_round_trip;
      logic [127:0] k, p, c;
      int seen;
      for (int n = 0; n < 1000; n++) begin
         k = {$urandom, $urandom, $urandom, $urandom};
         p = {$urandom, $urandom, $urandom, $urandom};
         c = m_encrypt(k, p);
         @(negedge clk);
         bus.start = 1'b1; bus.key = k; bus.in = c;
         seen = 0;
         for (int e = 1; e <= 20 && seen == 0; e++) begin
            @(negedge clk);
            bus.start = 1'b0;
            if (bus.done === 1'b1) seen = e;
         end
         checks++; if (seen != 11) begin errors++; $display("FAIL rt_latency[%0d]: done at edge %0d need 11", n, seen); end
         checks++; if (bus.out !== p) begin errors++; $display("FAIL rt_out[%0d]: got %h need %h", n, bus.out, p); end
      end
   endtask

   initial begin
      rst = 1'b1;
      bus.start = 1'b0;
      bus.key = '0;
      bus.in = '0;
      build_sbox();
      test_reset();
      test_c1();
      test_appb_latch();
      test_back_to_back();
      test_reset_mid();
      test_round_trip();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
